// File: rtl/abs_val_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : abs_val_pipe_pkg
// Purpose  : Shared helpers for signed-arithmetic blocks. Values are handled
//            sign-extended to 32 bits so one set of functions serves any
//            operand width from 2 to 32.
// Contents : abs_flags_t  - sign / most-negative flags travelling with a
//                           magnitude
//            mag_mask()   - all-ones magnitude for a given width
//            most_neg()   - -2^(width-1), sign-extended to 32 bits
//            abs_mag()    - magnitude with selectable most-negative policy
// Revision : 1.0 - initial release
// ============================================================================
package abs_val_pipe_pkg;

    localparam int CALC_W = 32;

    typedef struct packed {
        logic sign;    // sign bit of the original sample
        logic sat;     // sample was the most negative value
    } abs_flags_t;

    // Largest magnitude representable in width-1 bits.
    function automatic logic [CALC_W-1:0] mag_mask(input int width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

    // -2^(width-1) sign-extended to 32 bits (the complement of the mask).
    function automatic logic [CALC_W-1:0] most_neg(input int width);
        return ~mag_mask(width);
    endfunction

    // Magnitude of a sign-extended value. The most negative value has no
    // positive counterpart in width-1 bits: sat=1 clamps it to all ones,
    // sat=0 lets the negation wrap to zero. Result bits above width-2 are 0.
    function automatic logic [CALC_W-1:0] abs_mag(input logic [CALC_W-1:0] value,
                                                  input int                width,
                                                  input logic              sat);
        logic [CALC_W-1:0] mask;
        logic [CALC_W-1:0] neg;
        mask = mag_mask(width);
        neg  = ~value + 32'd1;
        if (value == most_neg(width)) begin
            return sat ? mask : 32'd0;
        end else if (value[CALC_W-1]) begin
            return neg & mask;
        end else begin
            return value & mask;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/abs_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : abs_pipe_stage
// Purpose  : Generic valid/ready register slice. Accepts a new word whenever
//            its output register is empty or being drained this cycle; holds
//            its contents otherwise. in_ready has no path from in_valid.
// Ports    : clock, reset_n          - clock, async active-low reset
//            in_valid/in_ready/in_data    - upstream handshake and payload
//            out_valid/out_ready/out_data - downstream handshake and payload
// Revision : 1.0 - initial release
// ============================================================================
module abs_pipe_stage #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    // Advance when empty or when the current word leaves this cycle.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            // Bubbles leave the data register untouched.
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/abs_val_pipe.sv
`default_nettype none
// ============================================================================
// Module   : abs_val_pipe
// Purpose  : Two-stage pipelined signed-to-magnitude converter with a
//            valid/ready stream interface, selectable most-negative policy
//            and a running peak-magnitude tracker.
//            Stage 1 registers the raw sample; stage 2 registers magnitude,
//            sign and saturation flag. Throughput is one sample per cycle.
// Ports    : clock, reset_n              - clock, async active-low reset
//            in_valid/in_ready/in_data   - signed WIDTH-bit input stream
//            out_valid/out_ready         - output handshake
//            out_mag/out_sign/out_sat    - WIDTH-1 bit magnitude and flags
//            peak_clear                  - synchronous peak tracker clear
//            peak_mag/peak_valid         - largest transferred magnitude
// Revision : 1.0 - initial release
// ============================================================================
module abs_val_pipe
    import abs_val_pipe_pkg::*;
#(
    parameter int WIDTH = 11,   // 2..32, including sign bit
    parameter bit SAT   = 1'b1  // 1: clamp most-negative to all ones, 0: wrap to 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-2:0] out_mag,
    output logic             out_sign,
    output logic             out_sat,
    input  logic             peak_clear,
    output logic [WIDTH-2:0] peak_mag,
    output logic             peak_valid
);

    localparam int MAG_W = WIDTH - 1;
    localparam int S2_W  = MAG_W + $bits(abs_flags_t);

    // ------------------------------------------------------------------
    // Stage 1: raw sample register
    // ------------------------------------------------------------------
    logic             s1_valid;
    logic             s1_ready;
    logic [WIDTH-1:0] s1_data;

    abs_pipe_stage #(
        .DATA_W (WIDTH)
    ) u_stage1 (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (s1_valid),
        .out_ready (s1_ready),
        .out_data  (s1_data)
    );

    // ------------------------------------------------------------------
    // Magnitude computation between the stages
    // ------------------------------------------------------------------
    logic [CALC_W-1:0] s1_ext;
    abs_flags_t        s1_flags;
    logic [MAG_W-1:0]  s1_mag;
    logic [S2_W-1:0]   s2_in;
    logic [S2_W-1:0]   s2_out;

    // Sign-extend to the package's working width.
    assign s1_ext         = CALC_W'(signed'(s1_data));
    assign s1_flags.sign  = s1_data[WIDTH-1];
    assign s1_flags.sat   = (s1_ext == most_neg(WIDTH));
    // abs_mag never sets bits above MAG_W-1, so the cast only drops zeros.
    assign s1_mag         = MAG_W'(abs_mag(s1_ext, WIDTH, SAT));
    assign s2_in          = {s1_flags, s1_mag};

    // ------------------------------------------------------------------
    // Stage 2: result register, drives the output port directly
    // ------------------------------------------------------------------
    abs_pipe_stage #(
        .DATA_W (S2_W)
    ) u_stage2 (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (s1_valid),
        .in_ready  (s1_ready),
        .in_data   (s2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_out)
    );

    assign {out_sign, out_sat, out_mag} = s2_out;

    // ------------------------------------------------------------------
    // Peak tracker
    // ------------------------------------------------------------------
    logic out_xfer;

    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            peak_mag   <= '0;
            peak_valid <= 1'b0;
        end else if (out_xfer) begin
            // A clear coinciding with a transfer restarts tracking from the
            // transferred value instead of discarding it.
            if (peak_clear || !peak_valid || (out_mag > peak_mag)) begin
                peak_mag <= out_mag;
            end
            peak_valid <= 1'b1;
        end else if (peak_clear) begin
            peak_mag   <= '0;
            peak_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_abs_val_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_abs_val_pipe
// Purpose  : Self-checking bench for abs_val_pipe. Four instances share one
//            stimulus stream and handshake:
//              0: WIDTH=11 SAT=1   1: WIDTH=11 SAT=0
//              2: WIDTH=5  SAT=0   3: WIDTH=16 SAT=1
//            Directed tables/sequences plus a scoreboard with an
//            independent integer reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_abs_val_pipe;

    localparam int NDUT = 4;
    localparam int DW [NDUT] = '{11, 11, 5, 16};
    localparam bit DS [NDUT] = '{1'b1, 1'b0, 1'b0, 1'b1};

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        peak_clear = 1'b0;
    logic [31:0] raw = 32'd0;

    logic        rdy_a, rdy_b, rdy_c, rdy_d;
    logic        val_a, val_b, val_c, val_d;
    logic [9:0]  mag_a, mag_b, pk_a, pk_b;
    logic [3:0]  mag_c, pk_c;
    logic [14:0] mag_d, pk_d;
    logic        sgn_a, sgn_b, sgn_c, sgn_d;
    logic        sat_a, sat_b, sat_c, sat_d;
    logic        pv_a, pv_b, pv_c, pv_d;

    always #5 clock = ~clock;

    abs_val_pipe #(.WIDTH(11), .SAT(1'b1)) u_dut_a (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_a),
        .in_data(raw[10:0]), .out_valid(val_a), .out_ready(out_ready),
        .out_mag(mag_a), .out_sign(sgn_a), .out_sat(sat_a),
        .peak_clear(peak_clear), .peak_mag(pk_a), .peak_valid(pv_a));

    abs_val_pipe #(.WIDTH(11), .SAT(1'b0)) u_dut_b (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_b),
        .in_data(raw[10:0]), .out_valid(val_b), .out_ready(out_ready),
        .out_mag(mag_b), .out_sign(sgn_b), .out_sat(sat_b),
        .peak_clear(peak_clear), .peak_mag(pk_b), .peak_valid(pv_b));

    abs_val_pipe #(.WIDTH(5), .SAT(1'b0)) u_dut_c (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_c),
        .in_data(raw[4:0]), .out_valid(val_c), .out_ready(out_ready),
        .out_mag(mag_c), .out_sign(sgn_c), .out_sat(sat_c),
        .peak_clear(peak_clear), .peak_mag(pk_c), .peak_valid(pv_c));

    abs_val_pipe #(.WIDTH(16), .SAT(1'b1)) u_dut_d (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(rdy_d),
        .in_data(raw[15:0]), .out_valid(val_d), .out_ready(out_ready),
        .out_mag(mag_d), .out_sign(sgn_d), .out_sat(sat_d),
        .peak_clear(peak_clear), .peak_mag(pk_d), .peak_valid(pv_d));

    // Uniform views of the four instances.
    int dmag [NDUT];
    int dpk  [NDUT];
    bit dsgn [NDUT];
    bit dsat [NDUT];
    bit dval [NDUT];
    bit dpv  [NDUT];
    bit drdy [NDUT];

    always_comb begin
        dmag[0] = int'(mag_a); dmag[1] = int'(mag_b); dmag[2] = int'(mag_c); dmag[3] = int'(mag_d);
        dpk[0]  = int'(pk_a);  dpk[1]  = int'(pk_b);  dpk[2]  = int'(pk_c);  dpk[3]  = int'(pk_d);
        dsgn[0] = sgn_a; dsgn[1] = sgn_b; dsgn[2] = sgn_c; dsgn[3] = sgn_d;
        dsat[0] = sat_a; dsat[1] = sat_b; dsat[2] = sat_c; dsat[3] = sat_d;
        dval[0] = val_a; dval[1] = val_b; dval[2] = val_c; dval[3] = val_d;
        dpv[0]  = pv_a;  dpv[1]  = pv_b;  dpv[2]  = pv_c;  dpv[3]  = pv_d;
        drdy[0] = rdy_a; drdy[1] = rdy_b; drdy[2] = rdy_c; drdy[3] = rdy_d;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int idx, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s dut%0d got=%0d want=%0d at t=%0t", name, idx, got, want, $time);
        end
    endtask

    // Reference: interpret the low w bits as signed, take |v| in int
    // arithmetic, then apply the most-negative policy.
    function automatic void model(input logic [31:0] r, input int w, input bit sat,
                                  output int mag, output bit sgn, output bit sf);
        int v;
        int half;
        half = 1 << (w - 1);
        v    = int'(r & ((32'd1 << w) - 32'd1));
        sgn  = r[w-1];
        if (sgn) v = v - 2 * half;
        mag = (v < 0) ? -v : v;
        sf  = (mag == half);
        if (sf) mag = sat ? half - 1 : 0;
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard / monitor, sampled on the falling edge
    // ------------------------------------------------------------------
    logic [31:0] sb [$];
    int          pk_m [NDUT];
    bit          pv_m [NDUT];
    bit          prev_stall = 1'b0;
    int          prev_mag;
    bit          prev_sgn, prev_sat;
    logic [31:0] mon_r;
    int          mon_m;
    bit          mon_s, mon_f;

    always @(negedge clock) begin
        if (!reset_n) begin
            sb.delete();
            for (int i = 0; i < NDUT; i++) begin
                pk_m[i] = 0;
                pv_m[i] = 1'b0;
            end
            prev_stall = 1'b0;
        end else begin
            for (int i = 0; i < NDUT; i++) begin
                check("peak_mag", i, dpk[i], pk_m[i]);
                check("peak_valid", i, int'(dpv[i]), int'(pv_m[i]));
                if (i > 0) begin
                    check("in_ready_match", i, int'(drdy[i]), int'(drdy[0]));
                    check("out_valid_match", i, int'(dval[i]), int'(dval[0]));
                end
            end
            if (prev_stall) begin
                check("stall_valid", 0, int'(dval[0]), 1);
                check("stall_mag", 0, dmag[0], prev_mag);
                check("stall_sign", 0, int'(dsgn[0]), int'(prev_sgn));
                check("stall_sat", 0, int'(dsat[0]), int'(prev_sat));
            end
            if (dval[0] && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 0, 1, 0);
                end else begin
                    mon_r = sb.pop_front();
                    for (int i = 0; i < NDUT; i++) begin
                        model(mon_r, DW[i], DS[i], mon_m, mon_s, mon_f);
                        check("sb_mag", i, dmag[i], mon_m);
                        check("sb_sign", i, int'(dsgn[i]), int'(mon_s));
                        check("sb_sat", i, int'(dsat[i]), int'(mon_f));
                        if (peak_clear || !pv_m[i] || mon_m > pk_m[i]) pk_m[i] = mon_m;
                        pv_m[i] = 1'b1;
                    end
                end
            end else if (peak_clear) begin
                for (int i = 0; i < NDUT; i++) begin
                    pk_m[i] = 0;
                    pv_m[i] = 1'b0;
                end
            end
            if (in_valid && drdy[0]) sb.push_back(raw);
            prev_stall = dval[0] && !out_ready;
            prev_mag   = dmag[0];
            prev_sgn   = dsgn[0];
            prev_sat   = dsat[0];
        end
    end

    // ------------------------------------------------------------------
    // Directed and random stimulus
    // ------------------------------------------------------------------
    typedef struct {
        int data;
        int mag_s;   // expected magnitude, SAT=1
        int mag_w;   // expected magnitude, SAT=0
        bit sgn;
        bit sat;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vt [NVEC];
    int   pseq [4] = '{3, 9, 4, 9};
    int   pexp [4] = '{3, 9, 9, 9};
    int   nxt, got, held;
    bit   seen_block, accept;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vt[0] = '{-5,    5,    5,    1'b1, 1'b0};
        vt[1] = '{7,     7,    7,    1'b0, 1'b0};
        vt[2] = '{0,     0,    0,    1'b0, 1'b0};
        vt[3] = '{-1024, 1023, 0,    1'b1, 1'b1};
        vt[4] = '{1023,  1023, 1023, 1'b0, 1'b0};
        vt[5] = '{-1,    1,    1,    1'b1, 1'b0};
        vt[6] = '{-1023, 1023, 1023, 1'b1, 1'b0};
        vt[7] = '{512,   512,  512,  1'b0, 1'b0};

        // Reset state
        reset_n = 1'b0;
        repeat (3) step();
        for (int i = 0; i < NDUT; i++) begin
            check("rst_out_valid", i, int'(dval[i]), 0);
            check("rst_out_mag", i, dmag[i], 0);
            check("rst_out_sign", i, int'(dsgn[i]), 0);
            check("rst_out_sat", i, int'(dsat[i]), 0);
            check("rst_peak_mag", i, dpk[i], 0);
            check("rst_peak_valid", i, int'(dpv[i]), 0);
            check("rst_in_ready", i, int'(drdy[i]), 1);
        end
        #2;
        reset_n = 1'b1;

        // Back-to-back table stream: output of sample i-1 visible after edge i
        out_ready = 1'b1;
        for (int i = 0; i <= NVEC; i++) begin
            if (i < NVEC) begin
                in_valid = 1'b1;
                raw      = vt[i].data;
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (i > 0) begin
                check("tbl_valid", i - 1, int'(val_a), 1);
                check("tbl_mag_sat1", i - 1, int'(mag_a), vt[i-1].mag_s);
                check("tbl_mag_sat0", i - 1, int'(mag_b), vt[i-1].mag_w);
                check("tbl_sign", i - 1, int'(sgn_a), int'(vt[i-1].sgn));
                check("tbl_sat1", i - 1, int'(sat_a), int'(vt[i-1].sat));
                check("tbl_sat0", i - 1, int'(sat_b), int'(vt[i-1].sat));
            end
        end
        repeat (2) step();

        // Backpressure: stream 1..6, stall the output for 4 cycles
        nxt = 1; got = 1; seen_block = 1'b0; held = -1;
        for (int c = 0; c < 40 && got <= 6; c++) begin
            out_ready = !(c >= 2 && c <= 5);
            in_valid  = (nxt <= 6);
            raw       = nxt;
            #1;
            if (!rdy_a) seen_block = 1'b1;
            if (c == 2) held = int'(mag_a);
            if (c == 5) check("bp_hold", 0, int'(mag_a), held);
            if (val_a && out_ready) begin
                check("bp_order", 0, int'(mag_a), got);
                got++;
            end
            accept = in_valid && rdy_a;
            step();
            if (accept) nxt++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_all_out", 0, got, 7);
        check("bp_in_ready_dropped", 0, int'(seen_block), 1);
        repeat (3) step();

        // Peak: start from a cleared tracker, then transfers 3,9,4,9
        peak_clear = 1'b1;
        step();
        peak_clear = 1'b0;
        for (int j = 0; j < 6; j++) begin
            in_valid = (j < 4);
            raw      = (j < 4) ? pseq[j] : 0;
            step();
            if (j >= 2) begin
                check("peak_seq", j - 2, int'(pk_a), pexp[j-2]);
                check("peak_seq_valid", j - 2, int'(pv_a), 1);
            end
        end
        in_valid = 1'b0;
        // Clear coinciding with a transfer of 2: tracker restarts at 2, not 9
        raw      = 2;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        check("peak_xfer_ready", 0, int'(val_a), 1);
        peak_clear = 1'b1;
        step();
        peak_clear = 1'b0;
        check("peak_clr_xfer", 0, int'(pk_a), 2);
        check("peak_clr_xfer_valid", 0, int'(pv_a), 1);
        // Clear with nothing transferring
        peak_clear = 1'b1;
        step();
        peak_clear = 1'b0;
        check("peak_clr_alone", 0, int'(pk_a), 0);
        check("peak_clr_alone_valid", 0, int'(pv_a), 0);

        // Asynchronous reset with both stages full
        raw      = 7;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        raw       = 5;
        step();
        raw = 6;
        step();
        in_valid = 1'b0;
        #1;
        check("pre_rst_full", 0, int'(rdy_a), 0);
        check("pre_rst_valid", 0, int'(val_a), 1);
        check("pre_rst_peak", 0, int'(pk_a), 7);
        check("pre_rst_peak_valid", 0, int'(pv_a), 1);
        #1;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check("arst_out_valid", i, int'(dval[i]), 0);
            check("arst_peak_valid", i, int'(dpv[i]), 0);
            check("arst_peak_mag", i, dpk[i], 0);
            check("arst_in_ready", i, int'(drdy[i]), 1);
        end
        @(posedge clock);
        #2;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        #1;
        check("post_rst_empty", 0, int'(val_a), 0);
        raw      = 32'hFFFF_FFF8;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("post_rst_lat1", 0, int'(val_a), 0);
        step();
        check("post_rst_lat2_valid", 0, int'(val_a), 1);
        check("post_rst_mag", 0, int'(mag_a), 8);
        check("post_rst_sign", 0, int'(sgn_a), 1);
        step();

        // Random traffic across all four instances
        for (int n = 0; n < 2000; n++) begin
            in_valid   = ($urandom_range(0, 9) < 7);
            raw        = $urandom;
            out_ready  = ($urandom_range(0, 9) < 7);
            peak_clear = ($urandom_range(0, 19) == 0);
            step();
        end
        in_valid   = 1'b0;
        peak_clear = 1'b0;
        out_ready  = 1'b1;
        repeat (4) step();
        @(negedge clock);
        #1;
        check("sb_drained", 0, sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "bench did not complete in time");
    end

endmodule
`default_nettype wire

// File: doc/abs_val_pipe.md
Name: abs_val_pipe

Overview:
Parametrised, pipelined signed-to-magnitude converter with a valid/ready stream interface, a selectable most-negative-value policy, and a running peak-magnitude tracker. It sits between the distance/angle arithmetic and the display/threshold logic. It replaces ad-hoc combinational absolute-value instances wherever results must be registered, backpressured or peak-held.

Parameters:
WIDTH, 11, input width in bits including sign; output magnitude is WIDTH-1 bits; legal range 2..32
SAT, 1, 1 = clamp most-negative input to all-ones magnitude; 0 = wrap to 0; out_sat asserts in both modes

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  in_data valid this cycle
in_ready  output  1  block accepts in_data this cycle
in_data  input  WIDTH  signed two's-complement sample
out_valid  output  1  out_mag/out_sign/out_sat valid
out_ready  input  1  downstream accepts output this cycle
out_mag  output  WIDTH-1  unsigned magnitude
out_sign  output  1  sign bit of the original sample
out_sat  output  1  sample was -2^(WIDTH-1)
peak_clear  input  1  synchronous clear of peak tracker
peak_mag  output  WIDTH-1  largest out_mag transferred since reset/clear
peak_valid  output  1  at least one transfer since reset/clear

Behaviour:
- Clock and reset: one clock, clock; reset_n is asynchronous and active-low. While reset_n=0, every register clears immediately: s1_valid=0, s2_valid=0, out_valid=0, out_mag=0, out_sign=0, out_sat=0, peak_mag=0, peak_valid=0. in_ready=1 out of reset.
- Pipeline, 2 stages.
  - S1 registers in_data.
  - S2 registers out_mag, out_sign and out_sat computed from S1.
  - Latency: a sample accepted at edge N is presented as out_valid=1 after edge N+1. Throughput is 1 sample per cycle.
- Handshake:
  - Input transfer on in_valid & in_ready; output transfer on out_valid & out_ready.
  - s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv; in_ready = s1_adv (combinational, no combinational path from in_valid).
  - A stage whose advance is low holds all of its data unchanged.
  - out_mag, out_sign and out_sat stay stable while out_valid=1 and out_ready=0.
  - No sample is dropped or duplicated.
- Arithmetic:
  - Sign bit s = in_data[WIDTH-1]. Magnitude = s ? (~in_data + 1) truncated to WIDTH-1 bits : in_data[WIDTH-2:0].
  - For in_data = -2^(WIDTH-1): out_sat=1. out_mag = all ones if SAT=1, 0 if SAT=0.
  - Zero gives out_mag=0, out_sign=0.
- Peak tracker (updates only on an output transfer):
  - If peak_valid=0 or out_mag > peak_mag, load peak_mag = out_mag. Set peak_valid=1.
  - peak_clear=1 with no transfer in the same cycle: peak_mag=0, peak_valid=0.
  - peak_clear and a transfer in the same cycle: peak_mag = transferred out_mag, peak_valid=1 (clear, then load).
  - Equal magnitude leaves peak_mag unchanged.
- Reset mid-stream discards in-flight samples; the first output after reset comes from the first sample accepted after reset.
- No internal overflow beyond the SAT case; output widths are exact.

Decomposition:
- Shared package: function for WIDTH-1 magnitude (two's-complement negate with SAT policy) and the constant MOST_NEG(WIDTH). Reused by other signed-arithmetic blocks.
- One natural sub-module, abs_pipe_stage: a generic valid/ready register slice of parametrised data width, instantiated twice.
- Peak tracker stays inline.

Test Plan:
1. WIDTH=11, SAT=1, out_ready=1; stream -5, 7, 0 on consecutive cycles -> out_mag 5, 7, 0 two edges after each input; out_sign 1, 0, 0; out_sat 0.
2. WIDTH=11, SAT=1 then SAT=0; input -1024 -> out_mag 1023 (SAT=1) / 0 (SAT=0), out_sat=1, out_sign=1. Input 1023 -> out_mag 1023, out_sat=0.
3. Backpressure: stream 1..6 with out_ready=0 for 4 cycles after first output -> in_ready drops once both stages are full; outputs 1..6 appear in order, none lost or repeated; out_mag stable while stalled.
4. Peak: transfers 3, 9, 4, 9 -> peak_mag 3, 9, 9, 9. peak_clear alone -> peak 0, peak_valid 0. peak_clear with transfer of 2 -> peak 2, peak_valid 1.
5. Reset mid-stream: assert reset_n=0 asynchronously (between edges) with both stages full -> out_valid, peak_valid and peak_mag drop to 0 immediately; after release, input -8 -> out_mag 8 at latency 2.
6. Random signed stream with random in_valid/out_ready, WIDTH=5 and WIDTH=16 -> scoreboard match of magnitude, sign, sat and peak against a reference model.
